// File: rtl/fp32_mul_operand_decode.sv
// FP32 multiplier input stage: classifies both operands, builds hidden-bit mantissas and
// the biased exponent sum, and buffers results in an output register plus one skid slot.

module fp32_operand_class (
    input  logic [31:0] op,
    output logic        nan,
    output logic        inf,
    output logic        zero,
    output logic        normal,
    output logic [7:0]  exp,
    output logic [23:0] mant
);
    logic exp_max;

    assign exp     = op[30:23];
    assign exp_max = (exp == 8'hFF);
    assign nan     = exp_max & (op[22:0] != 23'd0);
    assign inf     = exp_max & (op[22:0] == 23'd0);
    // Subnormals land here too: flushed to zero, sign still carried by res_sign.
    assign zero    = (exp == 8'd0);
    assign normal  = ~exp_max & ~zero;
    assign mant    = normal ? {1'b1, op[22:0]} : 24'd0;
endmodule

module fp32_mul_operand_decode #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        a_nan,
    output logic        b_nan,
    output logic        a_inf,
    output logic        b_inf,
    output logic        a_zero,
    output logic        b_zero,
    output logic        res_sign,
    output logic [23:0] a_mant,
    output logic [23:0] b_mant,
    output logic [9:0]  exp_sum
);
    typedef struct packed {
        logic        a_nan;
        logic        b_nan;
        logic        a_inf;
        logic        b_inf;
        logic        a_zero;
        logic        b_zero;
        logic        res_sign;
        logic [23:0] a_mant;
        logic [23:0] b_mant;
        logic [9:0]  exp_sum;
    } dec_t;

    logic [1:0][31:0] ops;
    logic [1:0]       nan_v, inf_v, zero_v, norm_v;
    logic [1:0][7:0]  exp_v;
    logic [1:0][23:0] mant_v;

    assign ops = {b, a};

    for (genvar i = 0; i < 2; i++) begin : g_cls
        fp32_operand_class u_cls (
            .op     (ops[i]),
            .nan    (nan_v[i]),
            .inf    (inf_v[i]),
            .zero   (zero_v[i]),
            .normal (norm_v[i]),
            .exp    (exp_v[i]),
            .mant   (mant_v[i])
        );
    end

    dec_t       dec;
    logic [9:0] sum_raw;

    assign sum_raw = {2'b00, exp_v[0]} + {2'b00, exp_v[1]} - 10'(BIAS);

    always_comb begin
        dec          = '0;
        dec.a_nan    = nan_v[0];
        dec.b_nan    = nan_v[1];
        dec.a_inf    = inf_v[0];
        dec.b_inf    = inf_v[1];
        dec.a_zero   = zero_v[0];
        dec.b_zero   = zero_v[1];
        dec.res_sign = a[31] ^ b[31];
        dec.a_mant   = mant_v[0];
        dec.b_mant   = mant_v[1];
        dec.exp_sum  = (&norm_v) ? sum_raw : 10'd0;
    end

    dec_t r_q, r_d, s_q, s_d;
    logic r_full, r_full_d, s_full, s_full_d, in_ready_q;
    logic accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        r_d      = r_q;
        s_d      = s_q;
        r_full_d = r_full;
        s_full_d = s_full;
        if (flush) begin
            r_d      = '0;
            s_d      = '0;
            r_full_d = 1'b0;
            s_full_d = 1'b0;
        end else if (~r_full | out_ready) begin
            // R is free or draining: refill from skid first, else from the input.
            if (s_full) begin
                r_d      = s_q;
                r_full_d = 1'b1;
                s_full_d = 1'b0;
            end else if (accept) begin
                r_d      = dec;
                r_full_d = 1'b1;
            end else begin
                r_full_d = 1'b0;
            end
        end else if (accept) begin
            s_d      = dec;
            s_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            s_q        <= '0;
            r_full     <= 1'b0;
            s_full     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            r_q        <= r_d;
            s_q        <= s_d;
            r_full     <= r_full_d;
            s_full     <= s_full_d;
            in_ready_q <= ~s_full_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = r_full;
    assign a_nan     = r_q.a_nan;
    assign b_nan     = r_q.b_nan;
    assign a_inf     = r_q.a_inf;
    assign b_inf     = r_q.b_inf;
    assign a_zero    = r_q.a_zero;
    assign b_zero    = r_q.b_zero;
    assign res_sign  = r_q.res_sign;
    assign a_mant    = r_q.a_mant;
    assign b_mant    = r_q.b_mant;
    assign exp_sum   = r_q.exp_sum;
endmodule
